// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard/stall controller (load-use stall, taken-branch
// flush, multi-cycle MDU occupancy of EX) with a saturating stall-cycle counter.
// Ports: clk/reset; ID sources rs1_d/rs2_d/use_rs*_d; EX info rd_e, mem_read_e,
//   branch_taken_e, mdu_start_e; outputs stall_f/d/e, flush_d/e/m, mdu_busy,
//   mdu_done, stall_cycles.
// Latency: all controls are combinational (same cycle); only FSM, cnt and counter are flops.
module hazard_ctrl #(
  parameter int REG_W   = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rs1_d,
  input  logic [REG_W-1:0] rs2_d,
  input  logic             use_rs1_d,
  input  logic             use_rs2_d,
  input  logic [REG_W-1:0] rd_e,
  input  logic             mem_read_e,
  input  logic             branch_taken_e,
  input  logic             mdu_start_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_m,
  output logic             mdu_busy,
  output logic             mdu_done,
  output logic [CNT_W-1:0] stall_cycles
);

  // cnt holds at most MDU_LAT-2; $clog2(MDU_LAT) is always >= 1 for MDU_LAT >= 2.
  localparam int CW = $clog2(MDU_LAT);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic             lu;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign lu = mem_read_e && (rd_e != '0) &&
              ((use_rs1_d && (rs1_d == rd_e)) || (use_rs2_d && (rs2_d == rd_e)));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_m  = 1'b0;
    mdu_done = 1'b0;
    mdu_busy = (state_q == BUSY);

    case (state_q)
      IDLE: begin
        if (mdu_start_e && !branch_taken_e) begin
          // First MDU cycle: freeze front end and keep EX/MEM empty while the op computes.
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          flush_m = 1'b1;
          cnt_d   = CW'(MDU_LAT - 2);
          state_d = BUSY;
        end else if (branch_taken_e) begin
          // Branch squashes the younger instructions, which also removes any load-use hazard.
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (lu) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          flush_m = 1'b1;
          cnt_d   = cnt_q - CW'(1);
        end else begin
          // Release cycle: the op leaves EX at this edge; a following MDU op restarts from IDLE.
          mdu_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset cycle: all controls quiet, state returns to IDLE with no done pulse.
    if (reset) begin
      state_d  = IDLE;
      cnt_d    = '0;
      stall_f  = 1'b0;
      stall_d  = 1'b0;
      stall_e  = 1'b0;
      flush_d  = 1'b0;
      flush_e  = 1'b0;
      flush_m  = 1'b0;
      mdu_done = 1'b0;
      mdu_busy = 1'b0;
    end
  end

  // Saturating count of cycles where the PC is held.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_f && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: main instance (CNT_W=32) plus a CNT_W=2 instance for saturation.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] rs1_d, rs2_d, rd_e;
  logic       use_rs1_d, use_rs2_d, mem_read_e, branch_taken_e, mdu_start_e;

  logic        stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_busy, mdu_done;
  logic [31:0] stall_cycles;

  logic       s_stall_f, s_stall_d, s_stall_e, s_flush_d, s_flush_e, s_flush_m, s_busy, s_done;
  logic [1:0] s_stall_cycles;

  int checks = 0;
  int errors = 0;

  // Control vector order: stall_f stall_d stall_e flush_d flush_e flush_m mdu_busy mdu_done
  localparam logic [7:0] C0 = 8'b0000_0000;
  localparam logic [7:0] LU = 8'b1100_1000;
  localparam logic [7:0] BR = 8'b0001_1000;
  localparam logic [7:0] MS = 8'b1110_0100;
  localparam logic [7:0] MB = 8'b1110_0110;
  localparam logic [7:0] MD = 8'b0000_0011;

  typedef struct {
    string       tag;
    logic [7:0]  ctl;
    logic [31:0] cnt;
    logic [1:0]  sat;
  } exp_t;

  exp_t sb[$];

  hazard_ctrl #(.REG_W(5), .MDU_LAT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d), .rd_e(rd_e),
    .mem_read_e(mem_read_e), .branch_taken_e(branch_taken_e), .mdu_start_e(mdu_start_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
    .mdu_busy(mdu_busy), .mdu_done(mdu_done), .stall_cycles(stall_cycles)
  );

  hazard_ctrl #(.REG_W(5), .MDU_LAT(4), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d), .rd_e(rd_e),
    .mem_read_e(mem_read_e), .branch_taken_e(branch_taken_e), .mdu_start_e(mdu_start_e),
    .stall_f(s_stall_f), .stall_d(s_stall_d), .stall_e(s_stall_e),
    .flush_d(s_flush_d), .flush_e(s_flush_e), .flush_m(s_flush_m),
    .mdu_busy(s_busy), .mdu_done(s_done), .stall_cycles(s_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, queue its expectation,
  // then compare the DUT outputs 2 ns later (well before the next rising edge).
  task automatic cyc(input string tag, input logic rst, input logic mr, input logic [4:0] rd,
                     input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                     input logic br, input logic mdu,
                     input logic [7:0] ectl, input logic [31:0] ecnt, input logic [1:0] esat);
    exp_t e;
    @(negedge clk);
    reset = rst; mem_read_e = mr; rd_e = rd; rs1_d = r1; use_rs1_d = u1;
    rs2_d = r2; use_rs2_d = u2; branch_taken_e = br; mdu_start_e = mdu;
    e.tag = tag; e.ctl = ectl; e.cnt = ecnt; e.sat = esat;
    sb.push_back(e);
    #2;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_ctl"}, {24'd0, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
                              mdu_busy, mdu_done}, {24'd0, e.ctl});
      check({e.tag, "_cnt"}, stall_cycles, e.cnt);
      check({e.tag, "_sat"}, {30'd0, s_stall_cycles}, {30'd0, e.sat});
    end
  endtask

  task automatic idle(input string tag, input logic [31:0] ecnt, input logic [1:0] esat);
    cyc(tag, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, C0, ecnt, esat);
  endtask

  task automatic mdu(input string tag, input logic [7:0] ectl, input logic [31:0] ecnt,
                     input logic [1:0] esat);
    cyc(tag, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, ectl, ecnt, esat);
  endtask

  initial begin
    reset = 1'b1; mem_read_e = 0; rd_e = 0; rs1_d = 0; rs2_d = 0;
    use_rs1_d = 0; use_rs2_d = 0; branch_taken_e = 0; mdu_start_e = 1;

    // Reset held two cycles with mdu_start_e high; counter state is only defined after one edge.
    @(negedge clk);
    #2;
    check("rst0_ctl", {24'd0, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_busy,
                       mdu_done}, 32'd0);
    cyc("rst1", 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, C0, 0, 0);
    idle("post_rst", 0, 0);

    // Load-use through rs2, then the non-stalling variants.
    cyc("lu_rs2", 0, 1, 5'd5, 5'd0, 0, 5'd5, 1, 0, 0, LU, 0, 0);
    idle("after_lu", 1, 1);
    cyc("lu_x0", 0, 1, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, C0, 1, 1);
    cyc("lu_nouse", 0, 1, 5'd5, 5'd0, 0, 5'd5, 0, 0, 0, C0, 1, 1);
    cyc("br_over_lu", 0, 1, 5'd5, 5'd0, 0, 5'd5, 1, 1, 0, BR, 1, 1);
    idle("after_br", 1, 1);
    cyc("lu_rs1", 0, 1, 5'd7, 5'd7, 1, 5'd3, 1, 0, 0, LU, 1, 1);
    idle("after_lu1", 2, 2);

    // Single MDU op: 3 stall cycles, release on the 4th.
    mdu("m1_c0", MS, 2, 2);
    mdu("m1_c1", MB, 3, 3);
    mdu("m1_c2", MB, 4, 3);
    mdu("m1_c3", MD, 5, 3);
    idle("m1_end", 5, 3);

    // Two back-to-back MDU ops with no idle gap.
    mdu("bb_c0", MS, 5, 3);
    mdu("bb_c1", MB, 6, 3);
    mdu("bb_c2", MB, 7, 3);
    mdu("bb_c3", MD, 8, 3);
    mdu("bb_c4", MS, 8, 3);
    mdu("bb_c5", MB, 9, 3);
    mdu("bb_c6", MB, 10, 3);
    mdu("bb_c7", MD, 11, 3);
    idle("bb_end", 11, 3);

    // Branch beats a simultaneous MDU start; FSM must remain IDLE.
    cyc("mdu_br", 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, BR, 11, 3);
    idle("mdu_br_idle", 11, 3);

    // Reset in the third cycle of an MDU op.
    mdu("rm_c0", MS, 11, 3);
    mdu("rm_c1", MB, 12, 3);
    cyc("rm_rst", 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, C0, 13, 3);
    idle("rm_after", 0, 0);

    // Five stall cycles: the 2-bit counter saturates at 3.
    cyc("sat0", 0, 1, 5'd9, 5'd9, 1, 5'd0, 0, 0, 0, LU, 0, 0);
    cyc("sat1", 0, 1, 5'd9, 5'd9, 1, 5'd0, 0, 0, 0, LU, 1, 1);
    cyc("sat2", 0, 1, 5'd9, 5'd9, 1, 5'd0, 0, 0, 0, LU, 2, 2);
    cyc("sat3", 0, 1, 5'd9, 5'd9, 1, 5'd0, 0, 0, 0, LU, 3, 3);
    cyc("sat4", 0, 1, 5'd9, 5'd9, 1, 5'd0, 0, 0, 0, LU, 4, 3);
    idle("sat_end", 5, 3);

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
